// File: rtl/l2_next_line_prefetcher.sv
// Next-line prefetcher between L2 and the L2/pmem arbiter: one-line buffer,
// speculative next-line fetch, and demand match-fetch for buffered addresses.
module l2_next_line_prefetcher #(
  parameter int unsigned OFFSET_BITS = 5,
  parameter int unsigned PAGE_BITS   = 12,
  parameter bit          ENABLE      = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         L2_read,
  input  logic         L2_write,
  input  logic [31:0]  L2_addr,
  input  logic         L2_arb_resp,
  output logic [255:0] pre_l2_rdata,
  output logic         pre_l2_resp,
  output logic         pre_read,
  output logic [31:0]  pre_addr,
  input  logic [255:0] arb_pre_rdata,
  input  logic         arb_pre_resp
);

  localparam int unsigned LINE_W = 32 - OFFSET_BITS;

  typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;

  state_t        state, state_next;
  logic          buf_valid, buf_valid_next;
  logic [255:0]  buf_data, buf_data_next;
  logic [31:0]   pre_addr_q, pre_addr_next;
  logic          pend_valid, pend_valid_next;
  logic [31:0]   pend_addr, pend_addr_next;
  logic          discard, discard_next;
  logic          demand_owned, demand_owned_next;

  logic              match, wr_hit_buf;
  logic              cand_fire, cand_page_end, cand_dup;
  logic [LINE_W-1:0] cand_line;
  logic [31:0]       cand_nl;

  // Same full-width compare the arbiter uses to suppress its own demand read.
  assign match      = L2_read  && (L2_addr == pre_addr_q);
  assign wr_hit_buf = L2_write && (L2_addr == pre_addr_q);

  // A demand completion is the newer event and takes precedence over RESP.
  assign cand_fire     = (L2_arb_resp && L2_read) || (state == RESP);
  assign cand_line     = (L2_arb_resp && L2_read) ? L2_addr[31:OFFSET_BITS]
                                                  : pre_addr_q[31:OFFSET_BITS];
  assign cand_page_end = &cand_line[PAGE_BITS-OFFSET_BITS-1:0];
  assign cand_nl       = {cand_line + LINE_W'(1), {OFFSET_BITS{1'b0}}};
  assign cand_dup      = (cand_nl == pre_addr_q) && buf_valid;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // through this block can leave a value unassigned and infer a latch.
    state_next        = state;
    buf_valid_next    = buf_valid;
    buf_data_next     = buf_data;
    pre_addr_next     = pre_addr_q;
    pend_valid_next   = pend_valid;
    pend_addr_next    = pend_addr;
    discard_next      = discard;
    demand_owned_next = demand_owned;

    case (state)
      IDLE: begin
        if (match && buf_valid) begin
          state_next = RESP;
        end else if (match) begin
          // The arbiter will not fetch this line itself, so we must.
          state_next        = FETCH;
          demand_owned_next = 1'b1;
        end else if (pend_valid && !L2_read && !L2_write && ENABLE) begin
          state_next        = FETCH;
          pre_addr_next     = pend_addr;
          buf_valid_next    = 1'b0;
          pend_valid_next   = 1'b0;
          demand_owned_next = 1'b0;
        end
      end
      FETCH: begin
        if (arb_pre_resp) begin
          buf_data_next  = arb_pre_rdata;
          buf_valid_next = !discard;
          discard_next   = 1'b0;
          state_next     = ((demand_owned || match) && !discard && !wr_hit_buf)
                           ? RESP : IDLE;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (cand_fire && !cand_page_end && !cand_dup) begin
      pend_valid_next = 1'b1;
      pend_addr_next  = cand_nl;
    end

    // Writebacks invalidate last so they win over a same-cycle fill.
    if (wr_hit_buf) begin
      buf_valid_next = 1'b0;
      if (state == FETCH && !arb_pre_resp) discard_next = 1'b1;
    end
    if (L2_write && (L2_addr == pend_addr_next)) pend_valid_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      buf_valid    <= 1'b0;
      // NOTE: the line buffer is a plain register, not a RAM, so clearing it
      // on reset is cheap and gives a defined pre_l2_rdata after reset.
      buf_data     <= '0;
      pre_addr_q   <= '0;
      pend_valid   <= 1'b0;
      pend_addr    <= '0;
      discard      <= 1'b0;
      demand_owned <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples the same
      // pre-edge values regardless of statement order.
      state        <= state_next;
      buf_valid    <= buf_valid_next;
      buf_data     <= buf_data_next;
      pre_addr_q   <= pre_addr_next;
      pend_valid   <= pend_valid_next;
      pend_addr    <= pend_addr_next;
      discard      <= discard_next;
      demand_owned <= demand_owned_next;
    end
  end

  assign pre_read     = (state == FETCH) && !reset;
  assign pre_l2_resp  = (state == RESP)  && !reset;
  assign pre_l2_rdata = buf_data;
  assign pre_addr     = pre_addr_q;

endmodule

// File: tb/tb_l2_next_line_prefetcher.sv
// Self-checking bench: transaction-level memory/prefetch model feeding a
// scoreboard, with a monitor that checks every response and prefetch request.
module tb_l2_next_line_prefetcher;

  logic         clk = 1'b0;
  logic         reset;
  logic         L2_read, L2_write, L2_arb_resp;
  logic [31:0]  L2_addr;
  logic [255:0] pre_l2_rdata;
  logic         pre_l2_resp, pre_read;
  logic [31:0]  pre_addr;
  logic [255:0] arb_pre_rdata;
  logic         arb_pre_resp;

  always #5 clk = ~clk;

  l2_next_line_prefetcher dut (
    .clk          (clk),
    .reset        (reset),
    .L2_read      (L2_read),
    .L2_write     (L2_write),
    .L2_addr      (L2_addr),
    .L2_arb_resp  (L2_arb_resp),
    .pre_l2_rdata (pre_l2_rdata),
    .pre_l2_resp  (pre_l2_resp),
    .pre_read     (pre_read),
    .pre_addr     (pre_addr),
    .arb_pre_rdata(arb_pre_rdata),
    .arb_pre_resp (arb_pre_resp)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: memory contents are versioned per line; the prefetcher's
  // buffer address/validity are tracked at transaction granularity.
  int unsigned  ver[bit [31:0]];
  bit [31:0]    m_pre_addr;
  bit           m_buf_valid;
  logic [255:0] exp_q[$];
  logic [31:0]  pf_q[$];
  bit           hold_arb = 1'b0;

  function automatic logic [255:0] mem_line(input bit [31:0] a);
    int unsigned v;
    v = ver.exists(a) ? ver[a] : 0;
    return {8{a ^ (v * 32'h9E37_79B9)}};
  endfunction

  function automatic void mem_write(input bit [31:0] a);
    ver[a] = ver.exists(a) ? ver[a] + 1 : 1;
  endfunction

  // Arbiter prefetch port: answers each request after a random delay.
  initial begin
    int d;
    arb_pre_resp  = 1'b0;
    arb_pre_rdata = '0;
    forever begin
      @(negedge clk);
      if (pre_read && !hold_arb && !reset) begin
        d = $urandom_range(2, 6);
        repeat (d - 1) @(negedge clk);
        arb_pre_rdata = mem_line(pre_addr);
        arb_pre_resp  = 1'b1;
        @(negedge clk);
        arb_pre_resp = 1'b0;
        check("pre_read_drop_after_resp", 256'(pre_read), 256'(0));
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT responds or requests.
  initial begin
    logic        prev_read;
    logic [31:0] prev_addr;
    prev_read = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_read = 1'b0;
      end else begin
        if (pre_l2_resp) begin
          if (exp_q.size() == 0) check("unexpected_resp", 256'(pre_l2_resp), 256'(0));
          else                   check("resp_data", pre_l2_rdata, exp_q.pop_front());
        end
        if (pre_read && !prev_read) begin
          if (pf_q.size() == 0) check("unexpected_prefetch", 256'(pre_read), 256'(0));
          else                  check("prefetch_addr", 256'(pre_addr), 256'(pf_q.pop_front()));
        end else if (pre_read && prev_read) begin
          check("pre_addr_stable", 256'(pre_addr), 256'(prev_addr));
        end
        prev_read = pre_read;
        prev_addr = pre_addr;
      end
    end
  end

  // mode: 0 normal, 1 write the prefetched line while it is in flight,
  // 2 return as soon as the prefetch is launched (arbiter held off).
  task automatic do_read(input bit [31:0] a, input int mode);
    bit        match, hit, pf;
    bit [31:0] nl;
    int        t;
    match = (a == m_pre_addr);
    hit   = match && m_buf_valid;
    L2_addr = a;
    L2_read = 1'b1;
    if (match) begin
      exp_q.push_back(mem_line(a));
      if (!hit) pf_q.push_back(a);
      t = 0;
      do begin @(negedge clk); t++; end while (!pre_l2_resp && t < 40);
      check("resp_seen", 256'(pre_l2_resp), 256'(1));
      if (hit) check("hit_latency", 256'(t), 256'(1));
      m_buf_valid = 1'b1;
    end else begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      L2_arb_resp = 1'b1;
      @(negedge clk);
      L2_arb_resp = 1'b0;
    end
    L2_read = 1'b0;

    nl = a + 32;
    pf = (a % 4096) != (4096 - 32);
    if (pf && nl == m_pre_addr && m_buf_valid) pf = 1'b0;
    if (pf) begin
      pf_q.push_back(nl);
      m_pre_addr  = nl;
      m_buf_valid = 1'b1;
      t = 0;
      while (!pre_read && t < 4) begin @(negedge clk); t++; end
      check("prefetch_launched", 256'(pre_read), 256'(1));
      if (mode == 2) return;
      if (mode == 1) begin
        L2_addr  = nl;
        L2_write = 1'b1;
        mem_write(nl);
        m_buf_valid = 1'b0;
        @(negedge clk);
        L2_write = 1'b0;
      end
    end
    repeat (12) @(negedge clk);
    check("scoreboard_drained", 256'(exp_q.size() + pf_q.size()), 256'(0));
    check("idle_after_read", 256'(pre_read), 256'(0));
  endtask

  task automatic do_write(input bit [31:0] a);
    L2_addr  = a;
    L2_write = 1'b1;
    repeat ($urandom_range(1, 2)) @(negedge clk);
    L2_write = 1'b0;
    mem_write(a);
    if (a == m_pre_addr) m_buf_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_write", 256'(pre_read), 256'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", n_checks);
    $fatal(1);
  end

  initial begin
    int unsigned r;
    bit [31:0]   a;
    reset       = 1'b1;
    L2_read     = 1'b0;
    L2_write    = 1'b0;
    L2_arb_resp = 1'b0;
    L2_addr     = '0;
    repeat (3) @(negedge clk);
    check("reset_pre_read", 256'(pre_read), 256'(0));
    check("reset_pre_l2_resp", 256'(pre_l2_resp), 256'(0));
    check("reset_pre_addr", 256'(pre_addr), 256'(0));
    check("reset_rdata", pre_l2_rdata, 256'(0));
    reset = 1'b0;
    m_pre_addr  = '0;
    m_buf_valid = 1'b0;
    @(negedge clk);

    do_read(32'h0000_0000, 0);
    do_read(32'h0000_1000, 0);
    do_read(32'h0000_1020, 0);
    do_read(32'h0000_1FE0, 0);
    do_read(32'hFFFF_FFE0, 0);
    do_read(32'h0000_2000, 1);
    do_read(32'h0000_2020, 0);
    do_write(32'h0000_2020);
    do_read(32'h0000_2020, 0);

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 99);
      case ($urandom_range(0, 3))
        0:       a = 32'h0000_1FA0 + 32'($urandom_range(0, 2)) * 32;
        1:       a = 32'hFFFF_FFA0 + 32'($urandom_range(0, 2)) * 32;
        2:       a = 32'h0000_5000 + 32'($urandom_range(0, 3)) * 32;
        default: a = m_pre_addr;
      endcase
      if ($urandom_range(0, 2) == 0) a = m_pre_addr;
      if (r < 20)      do_write(a);
      else if (r < 30) do_read(a, 1);
      else             do_read(a, 0);
    end

    hold_arb = 1'b1;
    a = (m_pre_addr == 32'h0000_3000) ? 32'h0000_3100 : 32'h0000_3000;
    do_read(a, 2);
    repeat (2) @(negedge clk);
    check("stalled_fetch_active", 256'(pre_read), 256'(1));
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_fetch_pre_read", 256'(pre_read), 256'(0));
    check("reset_mid_fetch_resp", 256'(pre_l2_resp), 256'(0));
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_pre_read", 256'(pre_read), 256'(0));
    check("post_reset_pre_addr", 256'(pre_addr), 256'(0));
    m_pre_addr  = '0;
    m_buf_valid = 1'b0;
    hold_arb    = 1'b0;
    do_read(32'h0000_0000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
